// File: rtl/mesh_router_rr.sv
// mesh_router_rr: N-port mesh router core with per-input FIFOs, destination-addressed delivery,
// round-robin arbitration with burst hold and drop counting; MESH_ROUTER_BROADCAST_EN enables broadcast.
module mesh_router_rr #(
  parameter int DATA_SIZE  = 8,
  parameter int NUM_PORTS  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_fill_i,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] in_data_i,
  output logic [NUM_PORTS-1:0]           in_empty_o,
  output logic [NUM_PORTS-1:0]           out_fill_o,
  input  logic [NUM_PORTS-1:0]           out_empty_i,
  output logic [DATA_SIZE-1:0]           out_data_o,
  output logic [NUM_PORTS-1:0]           grant_o,
  output logic [7:0]                     drop_cnt_o
);
  localparam int DEST_W = $clog2(NUM_PORTS) + 1;
  localparam int PW     = $clog2(NUM_PORTS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int BW     = 4;
`ifdef MESH_ROUTER_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic [DATA_SIZE-1:0] r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]        r_rd  [NUM_PORTS];
  logic [AW-1:0]        r_wr  [NUM_PORTS];
  logic [CW-1:0]        r_cnt [NUM_PORTS];
  logic [DATA_SIZE-1:0] w_head [NUM_PORTS];
  logic [DEST_W-1:0]    w_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_push, w_pop, w_elig, w_rot;
  logic                 w_found, w_dv, w_bc, w_rst_ptr;
  logic [PW-1:0]        w_off, w_win, w_next;
  logic [PW:0]          w_sum;
  logic [DATA_SIZE-1:0] w_wdata;
  logic [DEST_W-1:0]    w_wdest;
  logic [BW-1:0]        w_burst;
  logic [PW-1:0]        r_ptr, r_last;
  logic [BW-1:0]        r_burst;
  logic [NUM_PORTS-1:0] r_grant, r_fill;
  logic [DATA_SIZE-1:0] r_data;
  logic [7:0]           r_drop;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
    assign w_head[g]     = r_mem[g][r_rd[g]];
    assign w_dest[g]     = w_head[g][DEST_W-1:0];
    assign in_empty_o[g] = r_cnt[g] < CW'(FIFO_DEPTH);
    assign w_push[g]     = in_fill_i[g] & in_empty_o[g];
    assign w_pop[g]      = w_found && (w_win == PW'(g));
    // invalid destinations stay eligible so they can be drained and counted
    assign w_elig[g]     = (r_cnt[g] != '0) &&
                           (w_dest[g] < DEST_W'(NUM_PORTS) ? |(out_empty_i & (NUM_PORTS'(1) << w_dest[g])) :
                            (BCAST && &w_dest[g]) ? &(out_empty_i | (NUM_PORTS'(1) << g)) : 1'b1);
  end

  assign w_rot   = NUM_PORTS'({w_elig, w_elig} >> r_ptr);
  assign w_found = |w_rot;

  always_comb begin
    w_off = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) w_off = w_rot[i] ? PW'(i) : w_off;
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= (PW+1)'(NUM_PORTS)) ? PW'(w_sum - (PW+1)'(NUM_PORTS)) : PW'(w_sum);
  assign w_next    = (w_win == PW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
  assign w_wdata   = w_head[w_win];
  assign w_wdest   = w_wdata[DEST_W-1:0];
  assign w_dv      = w_wdest < DEST_W'(NUM_PORTS);
  assign w_bc      = BCAST && &w_wdest;
  assign w_burst   = (w_win == r_last) ? r_burst + 1'b1 : BW'(1);
  assign w_rst_ptr = (w_burst == BW'(BURST_LEN)) || (r_cnt[w_win] == CW'(1) && !w_push[w_win]);

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (w_push[p]) r_mem[p][r_wr[p]] <= in_data_i[p*DATA_SIZE +: DATA_SIZE];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst) begin
        r_wr[p]  <= '0;
        r_rd[p]  <= '0;
        r_cnt[p] <= '0;
      end else begin
        if (w_push[p]) r_wr[p] <= r_wr[p] + 1'b1;
        if (w_pop[p]) r_rd[p] <= r_rd[p] + 1'b1;
        r_cnt[p] <= r_cnt[p] + CW'(w_push[p]) - CW'(w_pop[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_last  <= '0;
      r_burst <= '0;
      r_grant <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_drop  <= '0;
    end else begin
      r_grant <= w_found ? NUM_PORTS'(1) << w_win : '0;
      r_fill  <= !w_found ? '0 : w_dv ? NUM_PORTS'(1) << w_wdest : w_bc ? ~(NUM_PORTS'(1) << w_win) : '0;
      if (w_found && (w_dv || w_bc)) r_data <= w_wdata;
      if (w_found && !w_dv && !w_bc && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
      if (w_found) begin
        r_last  <= w_win;
        r_burst <= w_rst_ptr ? '0 : w_burst;
        r_ptr   <= w_rst_ptr ? w_next : w_win;
      end
    end
  end

  assign out_fill_o = r_fill;
  assign out_data_o = r_data;
  assign grant_o    = r_grant;
  assign drop_cnt_o = r_drop;
endmodule

// File: tb/tb_mesh_router_rr.sv
// tb_mesh_router_rr: queue-based reference model for two routers (BURST_LEN 1 and 2) on shared stimulus.
module tb_mesh_router_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  in_fill, out_empty;
  logic [39:0] in_data;
  logic [4:0]  ie [2];
  logic [4:0]  fo [2];
  logic [4:0]  go [2];
  logic [7:0]  dd [2];
  logic [7:0]  dr [2];
  int vec = 0, errs = 0;
`ifdef MESH_ROUTER_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam logic [4:0] RR1 [6] = '{5'h02, 5'h04, 5'h08, 5'h02, 5'h04, 5'h08};
  localparam logic [4:0] RR2 [6] = '{5'h02, 5'h02, 5'h04, 5'h04, 5'h08, 5'h08};
  localparam logic [7:0] RD1 [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
  localparam logic [7:0] RD2 [6] = '{8'h10, 8'h40, 8'h20, 8'h50, 8'h30, 8'h60};

  mesh_router_rr #(.BURST_LEN(1)) dut (
    .clk(clk), .rst(rst), .in_fill_i(in_fill), .in_data_i(in_data), .in_empty_o(ie[0]),
    .out_fill_o(fo[0]), .out_empty_i(out_empty), .out_data_o(dd[0]), .grant_o(go[0]), .drop_cnt_o(dr[0]));
  mesh_router_rr #(.BURST_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .in_fill_i(in_fill), .in_data_i(in_data), .in_empty_o(ie[1]),
    .out_fill_o(fo[1]), .out_empty_i(out_empty), .out_data_o(dd[1]), .grant_o(go[1]), .drop_cnt_o(dr[1]));

  logic [7:0] mq [10][$];
  int ptr [2], burst [2], last [2];
  int bl [2] = '{1, 2};
  logic [4:0] e_fill [2], e_grant [2];
  logic [7:0] e_data [2], e_drop [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int win;
      logic [7:0] w;
      logic [4:0] acc;
      win = -1; w = '0; acc = '0;
      if (rst) begin
        for (int p = 0; p < 5; p++) mq[k*5+p].delete();
        ptr[k] = 0; burst[k] = 0; last[k] = 0;
        e_fill[k] = '0; e_grant[k] = '0; e_data[k] = '0; e_drop[k] = '0;
      end else begin
        for (int i = 0; i < 5; i++) begin
          int p, d;
          p = (ptr[k] + i) % 5;
          if (win < 0 && mq[k*5+p].size() > 0) begin
            w = mq[k*5+p][0];
            d = int'(w[3:0]);
            if (d < 5 ? ((out_empty >> d) & 5'd1) != 5'd0 :
                (BC && d == 15) ? (out_empty | 5'(1 << p)) == 5'h1f : 1'b1) win = p;
          end
        end
        for (int p = 0; p < 5; p++) acc[p] = in_fill[p] && mq[k*5+p].size() < 4;
        if (win >= 0) w = mq[k*5+win].pop_front();
        for (int p = 0; p < 5; p++) if (acc[p]) mq[k*5+p].push_back(in_data[p*8 +: 8]);
        if (win >= 0) begin
          int d;
          d = int'(w[3:0]);
          burst[k] = (win == last[k]) ? burst[k] + 1 : 1;
          last[k] = win;
          if (burst[k] == bl[k] || mq[k*5+win].size() == 0) begin
            ptr[k] = (win + 1) % 5;
            burst[k] = 0;
          end else ptr[k] = win;
          e_grant[k] = 5'(1 << win);
          if (d < 5) begin
            e_fill[k] = 5'(1 << d); e_data[k] = w;
          end else if (BC && d == 15) begin
            e_fill[k] = 5'h1f & ~5'(1 << win); e_data[k] = w;
          end else begin
            e_fill[k] = '0;
            if (e_drop[k] != 8'hff) e_drop[k] = e_drop[k] + 8'd1;
          end
        end else begin
          e_fill[k] = '0; e_grant[k] = '0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] xe;
      for (int p = 0; p < 5; p++) xe[p] = mq[k*5+p].size() < 4;
      chk("in_empty", k, ie[k], xe);
      chk("out_fill", k, fo[k], e_fill[k]);
      chk("out_data", k, dd[k], e_data[k]);
      chk("grant", k, go[k], e_grant[k]);
      chk("drop_cnt", k, dr[k], e_drop[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic put(input int p, input logic [7:0] v);
    in_data[p*8 +: 8] = v;
    in_fill[p] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_fill = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_fill = '0; in_data = '0; out_empty = 5'h1f;
    tick(); tick();
    chk("rst_in_empty", 0, ie[0], 5'h1f);
    chk("rst_fill", 0, fo[0], 5'h00);
    chk("rst_data", 0, dd[0], 8'h00);
    chk("rst_grant", 0, go[0], 5'h00);
    chk("rst_drop", 0, dr[0], 8'h00);
    rst = 1'b0;
    put(1, 8'h12); tick(); in_fill = '0; tick();
    chk("s1_fill", 0, fo[0], 5'b00100);
    chk("s1_data", 0, dd[0], 8'h12);
    chk("s1_grant", 0, go[0], 5'b00010);
    tick();
    chk("s1_hold_data", 0, dd[0], 8'h12);
    chk("s1_idle_grant", 0, go[0], 5'b00000);
    do_reset();
    out_empty = 5'b11110;
    put(1, 8'h10); put(2, 8'h20); put(3, 8'h30); tick();
    put(1, 8'h40); put(2, 8'h50); put(3, 8'h60); tick();
    in_fill = '0; out_empty = 5'h1f;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_grant_bl1", 0, go[0], RR1[i]);
      chk("rr_grant_bl2", 1, go[1], RR2[i]);
      chk("rr_data_bl1", 0, dd[0], RD1[i]);
      chk("rr_data_bl2", 1, dd[1], RD2[i]);
    end
    do_reset();
    out_empty = 5'b11110;
    for (int i = 0; i < 5; i++) begin
      put(4, 8'(8'hA0 + i * 16)); tick();
      if (i == 2) chk("fifo_space_after3", 0, 32'(ie[0][4]), 1);
      if (i == 3) chk("fifo_full_after4", 0, 32'(ie[0][4]), 0);
    end
    in_fill = '0;
    chk("overflow_no_drop", 0, dr[0], 8'h00);
    out_empty = 5'h1f;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_data", 0, dd[0], 8'(8'hA0 + i * 16));
      chk("drain_fill", 0, fo[0], 5'b00001);
    end
    tick();
    chk("drain_done", 0, fo[0], 5'b00000);
    do_reset();
    put(0, 8'h07); tick(); in_fill = '0; tick();
    chk("drop_fill", 0, fo[0], 5'b00000);
    chk("drop_grant", 0, go[0], 5'b00001);
    chk("drop_cnt1", 0, dr[0], 8'd1);
    put(0, 8'h07);
    repeat (300) tick();
    in_fill = '0;
    repeat (3) tick();
    chk("drop_sat", 0, dr[0], 8'd255);
    chk("drop_sat", 1, dr[1], 8'd255);
    do_reset();
    out_empty = 5'b10111;
    put(2, 8'h23); put(4, 8'h41); tick(); in_fill = '0; tick();
    chk("block_grant4", 0, go[0], 5'b10000);
    chk("block_fill", 0, fo[0], 5'b00010);
    chk("block_data", 0, dd[0], 8'h41);
    tick(); tick();
    chk("block_wait", 0, go[0], 5'b00000);
    out_empty = 5'h1f; tick();
    chk("unblock_grant2", 0, go[0], 5'b00100);
    chk("unblock_fill", 0, fo[0], 5'b01000);
    chk("unblock_data", 0, dd[0], 8'h23);
    do_reset();
    put(1, 8'h0F); tick(); in_fill = '0; tick();
    chk("bc_grant", 0, go[0], 5'b00010);
`ifdef MESH_ROUTER_BROADCAST_EN
    chk("bc_fill", 0, fo[0], 5'b11101);
    chk("bc_data", 0, dd[0], 8'h0F);
`else
    chk("bc_fill", 0, fo[0], 5'b00000);
    chk("bc_drop", 0, dr[0], 8'd1);
`endif
    out_empty = '0;
    for (int p = 0; p < 5; p++) put(p, 8'(p * 16 + 1));
    tick(); tick();
    rst = 1'b1; tick();
    chk("midrst_in_empty", 0, ie[0], 5'h1f);
    chk("midrst_fill", 0, fo[0], 5'h00);
    rst = 1'b0; in_fill = '0; out_empty = 5'h1f; tick();
    chk("midrst_flushed", 0, go[0], 5'h00);
    for (int i = 0; i < 48; i++) begin
      in_fill = 5'(i * 11 + 3);
      for (int p = 0; p < 5; p++) in_data[p*8 +: 8] = 8'(i * 29 + p * 53);
      out_empty = 5'(i * 7 + 9);
      tick();
    end
    in_fill = '0; out_empty = 5'h1f;
    repeat (12) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
